// File: rtl/cdb_pkg.sv
// Shared definitions for the GPR and FPR common-data-bus arbiters.
package cdb_pkg;

  localparam int N_REQ_GPR = 4;
  localparam int N_REQ_FPR = 3;
  localparam int W_TAG     = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_FPU = 1;
  localparam int REQ_MEM = 2;
  localparam int REQ_IN  = 3;

  typedef struct packed {
    logic [W_TAG-1:0] tag;
    logic [31:0]      data;
  } cdb_t;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_req(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int IW = $clog2(N_REQ);

  // Walk the ring starting at ptr; the first hit latches the winner index.
  always_comb begin
    int  j;
    logic hit;
    j     = 0;
    hit   = 1'b0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j     = (int'(ptr_i) + k) % N_REQ;
      hit   = req_i[IW'(j)] && !any_o;
      idx_o = hit ? IW'(j) : idx_o;
      any_o = any_o || req_i[IW'(j)];
    end
    gnt_o = any_o ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_o) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational grant, registered broadcast stage,
// saturating count of cycles where a valid request lost arbitration.
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int W_TAG = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W_TAG-1:0]   req_tag,
  input  logic [N_REQ*32-1:0]      req_data,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [W_TAG-1:0]         cdb_tag,
  output logic [31:0]              cdb_data,
  output logic [$clog2(N_REQ)-1:0] cdb_src,
  output logic [31:0]              conflict_cnt
);
  import cdb_pkg::*;

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [W_TAG-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic [IW-1:0]    src_q, src_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0] pick_gnt_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic             xfer_s;
  logic [W_TAG-1:0] tag_arr_s  [N_REQ];
  logic [31:0]      data_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign tag_arr_s[g]  = req_tag[g*W_TAG +: W_TAG];
    assign data_arr_s[g] = req_data[g*32 +: 32];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // Reset and flush both mask the grant so no transfer can slip through.
  assign req_ready = (rst_n && !flush) ? pick_gnt_s : '0;
  assign xfer_s    = pick_any_s && rst_n && !flush;

  // Next-state for pointer, broadcast stage and conflict counter.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (xfer_s) begin
      ptr_d   = (pick_idx_s == IW'(N_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
      valid_d = 1'b1;
      tag_d   = tag_arr_s[pick_idx_s];
      data_d  = data_arr_s[pick_idx_s];
      src_d   = pick_idx_s;
    end else begin
      valid_d = 1'b0;
    end
    if (!flush && multi_req(8'(req_valid))) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= 32'd0;
      src_q   <= '0;
      cnt_q   <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cdb_valid    = valid_q;
  assign cdb_tag      = tag_q;
  assign cdb_data     = data_q;
  assign cdb_src      = src_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of cdb_arbiter against a behavioural ring model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int WT = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WT-1:0] req_tag;
  logic [N*32-1:0] req_data;
  logic            flush;
  logic            cdb_valid;
  logic [WT-1:0]   cdb_tag;
  logic [31:0]     cdb_data;
  logic [1:0]      cdb_src;
  logic [31:0]     conflict_cnt;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .W_TAG(WT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .conflict_cnt (conflict_cnt)
  );

  logic [WT-1:0] tag_a  [N];
  logic [31:0]   data_a [N];
  logic [N-1:0]  v_s;
  logic          flush_s;
  logic          rst_s;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_tag[g*WT +: WT]  = tag_a[g];
    assign req_data[g*32 +: 32] = data_a[g];
  end

  int          n_chk  = 0;
  int          n_fail = 0;
  int          m_ptr;
  logic        m_valid;
  logic [WT-1:0] m_tag;
  logic [31:0] m_data;
  int          m_src;
  logic [31:0] m_cnt;
  int          waits [N];
  int          last_win;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ring_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    rst_n     = rst_s;
    req_valid = v_s;
    flush     = flush_s;
    #1;
    w  = (rst_s && !flush_s) ? ring_winner(v_s, m_ptr) : -1;
    er = (w >= 0) ? N'(1 << w) : '0;
    check_eq("req_ready", 64'(req_ready), 64'(er));
    last_win = w;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = 32'd0; m_src = 0; m_cnt = 32'd0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!v_s[i]) waits[i] = 0;
        else if (w == i) begin
          check_eq("fairness", 64'(waits[i] <= N - 1), 64'd1);
          waits[i] = 0;
        end else if (!flush_s) waits[i]++;
      end
      if (w >= 0) begin
        m_valid = 1'b1; m_tag = tag_a[w]; m_data = data_a[w]; m_src = w;
        m_ptr = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      if (!flush_s && $countones(v_s) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    check_eq("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check_eq("cdb_tag", 64'(cdb_tag), 64'(m_tag));
    check_eq("cdb_data", 64'(cdb_data), 64'(m_data));
    check_eq("cdb_src", 64'(cdb_src), 64'(m_src));
    check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    logic [N-1:0] pend;
    rst_n = 1'b0; req_valid = '0; flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      tag_a[i] = WT'(i + 1); data_a[i] = 32'h1000_0000 + 32'(i); waits[i] = 0;
    end
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = 32'd0; m_src = 0; m_cnt = 32'd0;
    v_s = '0; flush_s = 1'b0; rst_s = 1'b0;

    // reset, then idle
    repeat (2) step();
    rst_s = 1'b1;
    repeat (3) step();
    check_eq("idle_cnt", 64'(conflict_cnt), 64'd0);

    // round robin from reset
    v_s = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rr_order", 64'(last_win), 64'(k % 4));
      check_eq("rr_src", 64'(cdb_src), 64'(k % 4));
    end
    check_eq("rr_cnt", 64'(conflict_cnt), 64'd8);

    // pointer wrap with sparse requests
    v_s = 4'b1000; step();
    check_eq("wrap_g3", 64'(last_win), 64'd3);
    v_s = 4'b1001; step();
    check_eq("wrap_g0", 64'(last_win), 64'd0);
    step();
    check_eq("wrap_skip", 64'(last_win), 64'd3);

    // transfer then flush
    data_a[2] = 32'hDEAD_BEEF;
    v_s = 4'b0100; step();
    check_eq("fl_valid_t1", 64'(cdb_valid), 64'd1);
    check_eq("fl_data_t1", 64'(cdb_data), 64'hDEAD_BEEF);
    flush_s = 1'b1; v_s = 4'b0110; step();
    check_eq("fl_nogrant", 64'(last_win), -64'sd1);
    check_eq("fl_valid_t2", 64'(cdb_valid), 64'd0);
    check_eq("fl_ptr", 64'(dut.ptr_q), 64'd3);
    flush_s = 1'b0;

    // reset mid-operation drops the transfer
    rst_s = 1'b0; v_s = 4'b0100; step();
    check_eq("rst_nogrant", 64'(last_win), -64'sd1);
    check_eq("rst_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_ptr", 64'(dut.ptr_q), 64'd0);
    rst_s = 1'b1;

    // counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    v_s = 4'b1111;
    repeat (3) step();
    check_eq("sat_cnt", 64'(conflict_cnt), 64'hFFFF_FFFF);

    // randomized traffic, requests held until transferred
    pend = '0;
    v_s  = '0;
    step();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1'b1;
          tag_a[i]  = WT'($urandom);
          data_a[i] = $urandom;
        end
      end
      flush_s = ($urandom_range(0, 9) == 0);
      rst_s   = ($urandom_range(0, 49) != 0);
      v_s     = pend;
      step();
      if (last_win >= 0) pend[last_win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
